// File: rtl/m68k_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m68k_uart_pkg
// Description : Shared definitions for the 68000-bus UART: register offsets,
//               STATUS/CTRL bit positions and the TX/RX state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package m68k_uart_pkg;

    // Register offsets (CPU address bits 2:1)
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS bit positions
    localparam int ST_RX_AVAIL   = 0;
    localparam int ST_TX_SPACE   = 1;
    localparam int ST_TX_BUSY    = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;
    localparam int ST_TX_DROP    = 5;
    localparam int ST_WIDTH      = 6;

    // CTRL bit positions
    localparam int CTRL_RX_IRQ_EN       = 0;
    localparam int CTRL_TX_EMPTY_IRQ_EN = 1;
    localparam int CTRL_WIDTH           = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Zero-extend a received byte onto the 16-bit data bus
    function automatic logic [15:0] byte_to_word(input logic [7:0] b);
        return {8'h00, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/m68k_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with registered
//               full/empty flags. Pushes while full and pops while empty are
//               ignored, so callers may assert them unconditionally.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push & ~r_full;
    assign w_do_pop  = pop & ~r_empty;
    assign rdata     = r_mem[r_rd_ptr];
    assign full      = r_full;
    assign empty     = r_empty;

    // Occupancy after this cycle; simultaneous push and pop leave it unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, count and flags; flags are registered from the next count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_FULL);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage array; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/m68k_uart.sv
`default_nettype none
// ============================================================================
// Module      : m68k_uart
// Description : 8N1 UART responder for the fx68k bus. Four word-spaced
//               registers (DATA, STATUS, CTRL, reserved), TX/RX FIFOs,
//               self-generated DTACK and a registered level interrupt.
//               Define M68K_UART_LOOPBACK_EN to feed the receiver from the
//               internal transmitter and park the txd pin high.
// Revision    : 1.0 - initial release
// ============================================================================
module m68k_uart
    import m68k_uart_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        rw,
    input  logic        lds_n,
    input  logic [1:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        dtack_n,
    output logic        txd,
    input  logic        rxd,
    output logic        irq
);

    localparam int c_DIV = CLK_HZ / BAUD;
    localparam int c_CW  = $clog2(c_DIV + 1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_DIV - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_DIV / 2 - 1);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic                  r_cs_q;
    logic                  w_cs_rise;
    logic                  w_acc;
    logic                  w_wr_data;
    logic                  w_rd_data;
    logic                  w_rd_stat;
    logic                  w_wr_ctrl;
    logic [15:0]           w_rd_val;
    logic [15:0]           r_dout;
    logic                  r_dtack_n;
    logic [CTRL_WIDTH-1:0] r_ctrl;
    logic [ST_WIDTH-1:0]   w_status;

    // FIFO hookup
    logic       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0] w_tx_rdata;
    logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0] w_rx_rdata;

    // Status sources
    logic w_tx_drop, w_rx_overrun, w_frame_err, w_tx_busy;
    logic r_tx_drop, r_rx_overrun, r_frame_err;
    logic r_irq;

    // TX datapath
    tx_state_t       r_tx_state;
    logic [c_CW-1:0] r_tx_cnt;
    logic [2:0]      r_tx_bit;
    logic [7:0]      r_tx_shift;
    logic            r_txd;
    logic            w_tx_tick;

    // RX datapath
    rx_state_t       r_rx_state;
    logic [c_CW-1:0] r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic            r_rx_s1, r_rx_s2;
    logic            r_rx_wait_high;
    logic            w_rx_tick;
    logic            w_rx_stop_done;
    logic            w_rx_src;
    logic            w_unused;

`ifdef M68K_UART_LOOPBACK_EN
    assign w_rx_src = r_txd;
    assign txd      = 1'b1;
    assign w_unused = ^{din[15:8], rxd};
`else
    assign w_rx_src = rxd;
    assign txd      = r_txd;
    assign w_unused = ^din[15:8];
`endif

    // One action per chip-select assertion; lds_n=1 cycles only get DTACK
    assign w_cs_rise = cs & ~r_cs_q;
    assign w_acc     = w_cs_rise & ~lds_n;
    assign w_wr_data = w_acc & ~rw & (addr == REG_DATA);
    assign w_rd_data = w_acc &  rw & (addr == REG_DATA);
    assign w_rd_stat = w_acc &  rw & (addr == REG_STATUS);
    assign w_wr_ctrl = w_acc & ~rw & (addr == REG_CTRL);

    assign w_tx_push = w_wr_data & ~w_tx_full;
    assign w_tx_drop = w_wr_data &  w_tx_full;
    assign w_rx_pop  = w_rd_data & ~w_rx_empty;

    assign w_tx_busy = (r_tx_state != TX_IDLE) | ~w_tx_empty;

    always_comb begin
        w_status                = '0;
        w_status[ST_RX_AVAIL]   = ~w_rx_empty;
        w_status[ST_TX_SPACE]   = ~w_tx_full;
        w_status[ST_TX_BUSY]    = w_tx_busy;
        w_status[ST_RX_OVERRUN] = r_rx_overrun;
        w_status[ST_FRAME_ERR]  = r_frame_err;
        w_status[ST_TX_DROP]    = r_tx_drop;
    end

    // Read mux; evaluated at the cs rising edge and frozen into r_dout
    always_comb begin
        w_rd_val = '0;
        if (rw && !lds_n) begin
            case (addr)
                REG_DATA:   w_rd_val = w_rx_empty ? 16'h0000 : byte_to_word(w_rx_rdata);
                REG_STATUS: w_rd_val = {{(16 - ST_WIDTH){1'b0}}, w_status};
                REG_CTRL:   w_rd_val = {{(16 - CTRL_WIDTH){1'b0}}, r_ctrl};
                default:    w_rd_val = '0;
            endcase
        end
    end

    // Bus handshake: DTACK/data held while cs stays high, released after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_q    <= 1'b0;
            r_dtack_n <= 1'b1;
            r_dout    <= '0;
        end else begin
            r_cs_q <= cs;
            if (w_cs_rise) begin
                r_dtack_n <= 1'b0;
                r_dout    <= w_rd_val;
            end else if (!cs) begin
                r_dtack_n <= 1'b1;
                r_dout    <= '0;
            end
        end
    end

    assign dout    = r_dout;
    assign dtack_n = r_dtack_n;

    // CTRL register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= din[CTRL_WIDTH-1:0];
        end
    end

    // Sticky error flags; a new event wins over a simultaneous STATUS read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_drop    <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_tx_drop    <= w_tx_drop    | (r_tx_drop    & ~w_rd_stat);
            r_rx_overrun <= w_rx_overrun | (r_rx_overrun & ~w_rd_stat);
            r_frame_err  <= w_frame_err  | (r_frame_err  & ~w_rd_stat);
        end
    end

    // Level interrupt, one cycle behind its cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_ctrl[CTRL_RX_IRQ_EN] & ~w_rx_empty)
                   | (r_ctrl[CTRL_TX_EMPTY_IRQ_EN] & ~w_tx_busy);
        end
    end

    assign irq = r_irq;

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_tx_push),
        .wdata (din[7:0]),
        .pop   (w_tx_pop),
        .rdata (w_tx_rdata),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_rx_push),
        .wdata (r_rx_shift),
        .pop   (w_rx_pop),
        .rdata (w_rx_rdata),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    assign w_tx_tick = (r_tx_cnt == c_BIT_LAST);

    // Pop from IDLE, or at the end of STOP so frames run back to back
    assign w_tx_pop = ~w_tx_empty &
                      ((r_tx_state == TX_IDLE) |
                       ((r_tx_state == TX_STOP) & w_tx_tick));

    // TX FSM: start bit, 8 data bits LSB first, stop bit, DIV cycles each
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= '0;
                    if (!w_tx_empty) begin
                        r_tx_state <= TX_START;
                        r_tx_shift <= w_tx_rdata;
                        r_txd      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_tx_tick) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                        r_txd      <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= TX_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_txd      <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (!w_tx_empty) begin
                            r_tx_state <= TX_START;
                            r_tx_shift <= w_tx_rdata;
                            r_txd      <= 1'b0;
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_txd      <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    // Two-flop synchronizer; resets to the idle (mark) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= w_rx_src;
            r_rx_s2 <= r_rx_s1;
        end
    end

    assign w_rx_tick      = (r_rx_cnt == c_BIT_LAST);
    assign w_rx_stop_done = (r_rx_state == RX_STOP) & w_rx_tick;
    assign w_rx_push      = w_rx_stop_done &  r_rx_s2 & ~w_rx_full;
    assign w_rx_overrun   = w_rx_stop_done &  r_rx_s2 &  w_rx_full;
    assign w_frame_err    = w_rx_stop_done & ~r_rx_s2;

    // RX FSM: mid-bit sampling; after a framing error the line must return
    // high before a new start bit is accepted, so a held-low line (break)
    // is not decoded as a stream of bogus frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state     <= RX_IDLE;
            r_rx_cnt       <= '0;
            r_rx_bit       <= '0;
            r_rx_shift     <= '0;
            r_rx_wait_high <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_s2) begin
                        r_rx_wait_high <= 1'b0;
                    end else if (!r_rx_wait_high) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == c_HALF_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (!r_rx_s2) r_rx_wait_high <= 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
